// File: rtl/pin_verifier.sv
// -----------------------------------------------------------------------------
// pin_verifier
//
// Checks a BCD PIN entry against a stored PIN. It counts consecutive failed
// attempts and locks out after MAX_TRIES of them. A correct entry opens a
// session (GRANTED). While the session is open, the PIN can be replaced.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   en            block enable; gates submit (and so change_pin)
//   submit        single-cycle pulse, entry valid this cycle
//   entry         4*DIGITS bits of BCD, digit 0 in the LSBs
//   change_pin    level, sampled with submit in GRANTED
//   logout        single-cycle pulse, closes the session
//   granted       high while in GRANTED
//   denied        high while in DENIED
//   locked        high while in LOCKED
//   bad_fmt       one-cycle pulse, submitted entry had a digit > 9
//   pin_changed   one-cycle pulse, new PIN stored
//   tries_left    attempts remaining before lockout
//   state         encoded FSM state (debug / LED display)
//
// Input protocol: submit and logout are fire-and-forget pulses with no
// back-pressure. A submit the FSM cannot use in its current state is
// dropped silently; bad_fmt pulses only where an entry would be consumed.
// All outputs are registered. A submit at cycle N shows its verdict on
// granted/denied/locked at cycle N+2. bad_fmt and pin_changed appear at
// cycle N+1, which is the cycle a valid entry would spend in CHECK.
// -----------------------------------------------------------------------------
module pin_verifier #(
    parameter int                  DIGITS      = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_PIN = 16'h1234,
    parameter int                  MAX_TRIES   = 3,
    parameter int unsigned         HOLD_CYCLES = 100000000,
    parameter int unsigned         LOCK_CYCLES = 1000000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  submit,
    input  logic [4*DIGITS-1:0]   entry,
    input  logic                  change_pin,
    input  logic                  logout,
    output logic                  granted,
    output logic                  denied,
    output logic                  locked,
    output logic                  bad_fmt,
    output logic                  pin_changed,
    output logic [2:0]            tries_left,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_GRANTED = 3'd2,
        S_DENIED  = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    localparam logic [2:0]  TRIES_FULL = 3'(MAX_TRIES);
    localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_CYCLES - 1);

    state_t                state_q;
    logic [4*DIGITS-1:0]   pin_q;
    logic [4*DIGITS-1:0]   entry_q;
    logic [31:0]           timer_q;

    // High if any nibble of the word is outside 0..9.
    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] e);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (e[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    logic submit_ok;
    assign submit_ok = en & submit;

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pin_q       <= DEFAULT_PIN;
            entry_q     <= '0;
            timer_q     <= 32'd0;
            tries_left  <= TRIES_FULL;
            granted     <= 1'b0;
            denied      <= 1'b0;
            locked      <= 1'b0;
            bad_fmt     <= 1'b0;
            pin_changed <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised only by the branch
            // that produces them.
            bad_fmt     <= 1'b0;
            pin_changed <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    timer_q <= 32'd0;
                    if (submit_ok) begin
                        if (has_bad_digit(entry)) begin
                            bad_fmt <= 1'b1;
                        end else begin
                            entry_q <= entry;
                            state_q <= S_CHECK;
                        end
                    end
                end

                S_CHECK: begin
                    if (entry_q == pin_q) begin
                        state_q    <= S_GRANTED;
                        granted    <= 1'b1;
                        tries_left <= TRIES_FULL;
                        timer_q    <= 32'd0;
                    end else if (tries_left > 3'd1) begin
                        state_q    <= S_DENIED;
                        denied     <= 1'b1;
                        tries_left <= tries_left - 3'd1;
                        timer_q    <= HOLD_LOAD;
                    end else begin
                        state_q    <= S_LOCKED;
                        locked     <= 1'b1;
                        tries_left <= 3'd0;
                        timer_q    <= LOCK_LOAD;
                    end
                end

                S_GRANTED: begin
                    timer_q <= 32'd0;
                    // logout wins over a submit in the same cycle.
                    if (logout) begin
                        state_q <= S_IDLE;
                        granted <= 1'b0;
                    end else if (submit_ok && change_pin) begin
                        if (has_bad_digit(entry)) begin
                            bad_fmt <= 1'b1;
                        end else begin
                            pin_q       <= entry;
                            pin_changed <= 1'b1;
                        end
                    end
                end

                S_DENIED: begin
                    // The timer is loaded with HOLD_CYCLES-1 on entry, so
                    // counting down to 0 inclusive gives HOLD_CYCLES cycles.
                    if (timer_q == 32'd0) begin
                        state_q <= S_IDLE;
                        denied  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end

                S_LOCKED: begin
                    if (timer_q == 32'd0) begin
                        state_q    <= S_IDLE;
                        locked     <= 1'b0;
                        tries_left <= TRIES_FULL;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    granted <= 1'b0;
                    denied  <= 1'b0;
                    locked  <= 1'b0;
                    timer_q <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pin_verifier.sv
// -----------------------------------------------------------------------------
// tb_pin_verifier
//
// The driver issues submits and logouts. For each one, a transaction-level
// model (stored PIN plus tries counter) predicts which output events should
// follow. It pushes them into exp_q. A monitor on the falling clock edge
// turns output rises and falls into the same event words. Each event carries
// the kind, state, tries_left, latency since the submit and pulse width. The
// monitor then compares each event with the head of the queue.
// -----------------------------------------------------------------------------
module tb_pin_verifier;

    localparam int          DIGITS = 4;
    localparam int          W      = 26;
    localparam int          HOLD   = 8;
    localparam int          LOCK   = 20;
    localparam int          MAXT   = 3;
    localparam logic [15:0] DEFPIN = 16'h1234;

    localparam logic [3:0] K_G  = 4'd1;  // granted rise
    localparam logic [3:0] K_GE = 4'd2;  // granted fall
    localparam logic [3:0] K_D  = 4'd3;  // denied rise
    localparam logic [3:0] K_DE = 4'd4;  // denied fall (b = width)
    localparam logic [3:0] K_L  = 4'd5;  // locked rise
    localparam logic [3:0] K_LE = 4'd6;  // locked fall (b = width)
    localparam logic [3:0] K_BF = 4'd7;  // bad_fmt pulse
    localparam logic [3:0] K_PC = 4'd8;  // pin_changed pulse

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        submit;
    logic [15:0] entry;
    logic        change_pin;
    logic        logout;
    logic        granted;
    logic        denied;
    logic        locked;
    logic        bad_fmt;
    logic        pin_changed;
    logic [2:0]  tries_left;
    logic [2:0]  state;

    pin_verifier #(
        .DIGITS      (DIGITS),
        .DEFAULT_PIN (DEFPIN),
        .MAX_TRIES   (MAXT),
        .HOLD_CYCLES (HOLD),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .submit      (submit),
        .entry       (entry),
        .change_pin  (change_pin),
        .logout      (logout),
        .granted     (granted),
        .denied      (denied),
        .locked      (locked),
        .bad_fmt     (bad_fmt),
        .pin_changed (pin_changed),
        .tries_left  (tries_left),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int last_sub = 0;

    // Reference model state
    logic [15:0] pin_m;
    int          tries_m;

    function automatic logic [W-1:0] mk_ev(input logic [3:0] k, input logic [2:0] st,
                                           input logic [2:0] tr, input logic [7:0] a,
                                           input logic [7:0] b);
        return {k, st, tr, a, b};
    endfunction

    task automatic push(input logic [3:0] k, input int st, input int tr,
                        input int a, input int b);
        exp_q.push_back(mk_ev(k, 3'(st), 3'(tr), 8'(a), 8'(b)));
    endtask

    task automatic check_ev(input logic [W-1:0] got);
        logic [W-1:0] ex;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d st=%0d tries=%0d lat=%0d width=%0d, required none",
                     got[25:22], got[21:19], got[18:16], got[15:8], got[7:0]);
        end else begin
            ex = exp_q.pop_front();
            if (got !== ex) begin
                n_fail++;
                $display("FAIL event: got kind=%0d st=%0d tries=%0d lat=%0d width=%0d, required kind=%0d st=%0d tries=%0d lat=%0d width=%0d",
                         got[25:22], got[21:19], got[18:16], got[15:8], got[7:0],
                         ex[25:22], ex[21:19], ex[18:16], ex[15:8], ex[7:0]);
            end
        end
    endtask

    task automatic check_eq(input string name, input int got, input int req);
        n_tests++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // ---------------- monitor ----------------
    logic p_g = 1'b0, p_d = 1'b0, p_l = 1'b0, p_bf = 1'b0, p_pc = 1'b0;
    int   r_d = 0, r_l = 0, r_bf = 0, r_pc = 0;

    always @(negedge clk) begin
        if (granted === 1'b1 && !p_g) check_ev(mk_ev(K_G, state, tries_left, 8'(cyc - last_sub), 8'd0));
        if (granted === 1'b0 && p_g)  check_ev(mk_ev(K_GE, state, tries_left, 8'd0, 8'd0));
        if (denied === 1'b1 && !p_d) begin
            r_d = cyc;
            check_ev(mk_ev(K_D, state, tries_left, 8'(cyc - last_sub), 8'd0));
        end
        if (denied === 1'b0 && p_d)  check_ev(mk_ev(K_DE, state, tries_left, 8'd0, 8'(cyc - r_d)));
        if (locked === 1'b1 && !p_l) begin
            r_l = cyc;
            check_ev(mk_ev(K_L, state, tries_left, 8'(cyc - last_sub), 8'd0));
        end
        if (locked === 1'b0 && p_l)  check_ev(mk_ev(K_LE, state, tries_left, 8'd0, 8'(cyc - r_l)));
        if (bad_fmt === 1'b1 && !p_bf) r_bf = cyc;
        if (bad_fmt === 1'b0 && p_bf)
            check_ev(mk_ev(K_BF, state, tries_left, 8'(r_bf - last_sub), 8'(cyc - r_bf)));
        if (pin_changed === 1'b1 && !p_pc) r_pc = cyc;
        if (pin_changed === 1'b0 && p_pc)
            check_ev(mk_ev(K_PC, state, tries_left, 8'(r_pc - last_sub), 8'(cyc - r_pc)));
        p_g  = (granted === 1'b1);
        p_d  = (denied === 1'b1);
        p_l  = (locked === 1'b1);
        p_bf = (bad_fmt === 1'b1);
        p_pc = (pin_changed === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sub, input logic [15:0] e, input logic chg,
                         input logic lo, input logic en_v);
        @(posedge clk);
        #1;
        en = en_v; submit = sub; entry = e; change_pin = chg; logout = lo;
        if (sub) last_sub = cyc;
        @(posedge clk);
        #1;
        en = 1'b1; submit = 1'b0; change_pin = 1'b0; logout = 1'b0;
    endtask

    function automatic logic has_bad(input logic [15:0] e);
        for (int i = 0; i < DIGITS; i++)
            if (((e >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = 16'h0;
        for (int i = 0; i < DIGITS; i++) v = v | (16'($urandom_range(0, 9)) << (4 * i));
        return v;
    endfunction

    function automatic logic [15:0] rand_bad();
        logic [15:0] v;
        int          d;
        v = rand_bcd();
        d = $urandom_range(0, DIGITS - 1);
        v = (v & ~(16'hF << (4 * d))) | (16'($urandom_range(10, 15)) << (4 * d));
        return v;
    endfunction

    function automatic logic [15:0] rand_wrong();
        logic [15:0] v;
        v = rand_bcd();
        if (v == pin_m) v = pin_m ^ 16'h0001;  // flips digit 0 between 2k and 2k+1, stays BCD
        return v;
    endfunction

    // One submit from IDLE. The model predicts the outcome, the task rides
    // out any hold or lock, and res returns 0=bad 1=granted 2=denied 3=locked.
    // With rst_lock set, a resulting lockout is cut short by reset after 5 cycles.
    task automatic attempt(input logic [15:0] e, input logic rst_lock, output int res);
        drive(1'b1, e, 1'b0, 1'b0, 1'b1);
        if (has_bad(e)) begin
            res = 0;
            push(K_BF, 0, tries_m, 1, 1);
            wait_cycles(2);
        end else if (e == pin_m) begin
            res = 1;
            tries_m = MAXT;
            push(K_G, 2, MAXT, 2, 0);
            wait_cycles(2);
        end else if (tries_m > 1) begin
            res = 2;
            tries_m = tries_m - 1;
            push(K_D, 3, tries_m, 2, 0);
            push(K_DE, 0, tries_m, 0, HOLD);
            wait_cycles(1);
            drive(1'b1, pin_m, 1'b0, 1'b0, 1'b1);  // ignored during hold
            wait_cycles(HOLD + 2);
        end else begin
            res = 3;
            push(K_L, 4, 0, 2, 0);
            tries_m = MAXT;
            if (rst_lock) begin
                push(K_LE, 0, MAXT, 0, 5);
                wait_cycles(6);
                #1 rst = 1'b1;
                #1;
                check_eq("rst_in_lock_locked", int'(locked), 0);
                check_eq("rst_in_lock_state", int'(state), 0);
                check_eq("rst_in_lock_tries", int'(tries_left), MAXT);
                @(posedge clk);
                #1 rst = 1'b0;
                pin_m = DEFPIN;
                wait_cycles(2);
            end else begin
                push(K_LE, 0, MAXT, 0, LOCK);
                wait_cycles(1);
                drive(1'b1, pin_m, 1'b1, 1'b1, 1'b1);  // ignored during lock
                wait_cycles(LOCK + 2);
            end
        end
    endtask

    task automatic change_to(input logic [15:0] e);
        drive(1'b1, e, 1'b1, 1'b0, 1'b1);
        if (has_bad(e)) begin
            push(K_BF, 2, tries_m, 1, 1);
        end else begin
            pin_m = e;
            push(K_PC, 2, tries_m, 1, 1);
        end
        wait_cycles(2);
    endtask

    task automatic do_logout(input logic with_sub);
        push(K_GE, 0, tries_m, 0, 0);
        drive(with_sub, rand_bcd(), with_sub, 1'b1, 1'b1);
        wait_cycles(2);
    endtask

    task automatic random_session();
        int n;
        int op;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: change_to(rand_bcd());
                1: change_to(rand_bad());
                2: begin drive(1'b1, rand_bcd(), 1'b0, 1'b0, 1'b1); wait_cycles(2); end
                default: begin drive(1'b1, rand_bcd(), 1'b1, 1'b0, 1'b0); wait_cycles(2); end
            endcase
        end
        do_logout(1'($urandom_range(0, 1)));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          res;
        int          sel;
        logic [15:0] e;

        rst = 1'b1; en = 1'b1; submit = 1'b0; entry = 16'h0;
        change_pin = 1'b0; logout = 1'b0;
        pin_m = DEFPIN; tries_m = MAXT;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_flags", int'({granted, denied, locked, bad_fmt, pin_changed}), 0);
        check_eq("reset_tries", int'(tries_left), MAXT);
        check_eq("reset_state", int'(state), 0);

        // correct default PIN, then logout
        attempt(16'h1234, 1'b0, res);
        do_logout(1'b0);
        // wrong PIN: hold, then two more wrong -> lockout
        attempt(16'h1111, 1'b0, res);
        attempt(16'h1111, 1'b0, res);
        attempt(16'h1111, 1'b0, res);
        // invalid BCD in IDLE
        attempt(16'h12A4, 1'b0, res);
        // disabled submit of the right PIN is ignored
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        check_eq("en_low_state", int'(state), 0);
        // PIN change in session
        attempt(16'h1234, 1'b0, res);
        change_to(16'h9876);
        change_to(16'h55F5);
        do_logout(1'b0);
        attempt(16'h1234, 1'b0, res);
        attempt(16'h9876, 1'b0, res);
        do_logout(1'b0);
        // lock out, then reset mid-lock
        while (tries_m > 1) attempt(rand_wrong(), 1'b0, res);
        attempt(rand_wrong(), 1'b1, res);
        attempt(16'h1234, 1'b0, res);
        // logout with a simultaneous change submit: no change happens
        push(K_GE, 0, tries_m, 0, 0);
        drive(1'b1, 16'h5555, 1'b1, 1'b1, 1'b1);
        wait_cycles(2);
        attempt(16'h5555, 1'b0, res);
        attempt(16'h1234, 1'b0, res);
        do_logout(1'b0);

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      e = pin_m;
            else if (sel < 8) e = rand_wrong();
            else              e = rand_bad();
            attempt(e, 1'b0, res);
            if (res == 1) random_session();
        end

        wait_cycles(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
